// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified I/D memory arbiter.
// Holds the in-flight owner encoding, the streak counter width and the
// default starvation limit used by unified_mem_arbiter and arb_starve_cnt.
package mem_arb_pkg;

  // Owner of the access currently in flight in the SRAM's one-cycle read pipe.
  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_I_RD = 2'b01;
  localparam logic [1:0] OWN_D_RD = 2'b10;
  localparam logic [1:0] OWN_D_WR = 2'b11;

  // Streak counter width covers the full legal STARVE_LIMIT range 1..15.
  localparam int STREAK_W         = 4;
  localparam int STARVE_LIMIT_DEF = 4;

endpackage

// File: rtl/arb_starve_cnt.sv
// Starvation guard for the unified memory arbiter.
// Counts consecutive D grants made while the fetch port is waiting and
// raises force_i once the streak reaches STARVE_LIMIT.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_req      : fetch port is requesting
//   i_gnt      : fetch port granted this cycle
//   d_gnt      : data port granted this cycle
//   force_i    : next I request must win over D
module arb_starve_cnt
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_req,
  input  logic i_gnt,
  input  logic d_gnt,
  output logic force_i
);

  localparam logic [STREAK_W-1:0] LIMIT = STREAK_W'(STARVE_LIMIT);

  logic [STREAK_W-1:0] streak;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of always-block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak <= '0;
    end else if (i_gnt || !i_req) begin
      // Streak only measures how long a *waiting* fetch has been passed over.
      streak <= '0;
    end else if (d_gnt && (streak != LIMIT)) begin
      streak <= streak + 1'b1;
    end
  end

  assign force_i = (streak == LIMIT);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Unified instruction/data memory arbiter.
// Shares one single-port synchronous SRAM between the fetch (I) and data (D)
// ports of the core. D has fixed priority, except that a starvation guard
// forces an I grant after STARVE_LIMIT consecutive D wins. The owner of each
// access is registered so the word returning one cycle later is steered to
// the requester that issued it.
// Ports:
//   CLK, RSTn                        : clock, asynchronous active-low reset
//   I_REQ/I_ADDR/I_GNT               : fetch request, byte address, grant
//   I_RVALID/I_RDATA                 : fetch response (1 cycle after I_GNT)
//   D_REQ/D_WE/D_BE/D_ADDR/D_WDATA   : data request
//   D_GNT                            : data grant
//   D_RVALID/D_RDATA                 : read data or write ack
//   M_CSN/M_WEN/M_BE/M_ADDR/M_DI     : SRAM control (active-low CSN/WEN)
//   M_DOUT                           : SRAM read data, cycle after access
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AWIDTH       = 12,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              I_REQ,
  input  logic [31:0]       I_ADDR,
  output logic              I_GNT,
  output logic              I_RVALID,
  output logic [31:0]       I_RDATA,
  input  logic              D_REQ,
  input  logic              D_WE,
  input  logic [3:0]        D_BE,
  input  logic [31:0]       D_ADDR,
  input  logic [31:0]       D_WDATA,
  output logic              D_GNT,
  output logic              D_RVALID,
  output logic [31:0]       D_RDATA,
  output logic              M_CSN,
  output logic              M_WEN,
  output logic [3:0]        M_BE,
  output logic [AWIDTH-1:0] M_ADDR,
  output logic [31:0]       M_DI,
  input  logic [31:0]       M_DOUT
);

  logic       force_i;
  logic       win_i;
  logic       win_d;
  logic [1:0] owner;
  logic [1:0] owner_next;

  // Byte-offset bits and bits above the SRAM size are dropped on purpose:
  // addresses alias silently.
  logic addr_unused;
  assign addr_unused = ^{I_ADDR[31:AWIDTH+2], I_ADDR[1:0],
                         D_ADDR[31:AWIDTH+2], D_ADDR[1:0]};

  arb_starve_cnt #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk    (CLK),
    .rst_n  (RSTn),
    .i_req  (I_REQ),
    .i_gnt  (win_i),
    .d_gnt  (win_d),
    .force_i(force_i)
  );

  // Arbitration winner. Internal state consumes the raw winner; reset acts on
  // those flops asynchronously, so only the visible outputs need gating.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    win_i = 1'b0;
    win_d = 1'b0;
    if (force_i && I_REQ) begin
      win_i = 1'b1;
    end else if (D_REQ) begin
      win_d = 1'b1;
    end else if (I_REQ) begin
      win_i = 1'b1;
    end
  end

  assign I_GNT = RSTn & win_i;
  assign D_GNT = RSTn & win_d;

  // SRAM drive follows the visible grant, so reset parks the macro idle.
  always_comb begin
    M_CSN  = 1'b1;
    M_WEN  = 1'b1;
    M_BE   = 4'b0000;
    M_ADDR = '0;
    M_DI   = '0;
    if (I_GNT) begin
      M_CSN  = 1'b0;
      M_ADDR = I_ADDR[AWIDTH+1:2];
    end else if (D_GNT) begin
      M_CSN  = 1'b0;
      M_WEN  = ~D_WE;
      M_BE   = D_WE ? D_BE : 4'b0000;
      M_ADDR = D_ADDR[AWIDTH+1:2];
      M_DI   = D_WDATA;
    end
  end

  always_comb begin
    owner_next = OWN_NONE;
    if (win_i) begin
      owner_next = OWN_I_RD;
    end else if (win_d) begin
      owner_next = D_WE ? OWN_D_WR : OWN_D_RD;
    end
  end

  // Reloaded every cycle: one access in flight at most, so grants can issue
  // back to back with no bubbles.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      owner <= OWN_NONE;
    end else begin
      owner <= owner_next;
    end
  end

  // Response steering: data is passed straight from the macro, masked to
  // zero for the requester that does not own the returning word.
  assign I_RVALID = (owner == OWN_I_RD);
  assign I_RDATA  = I_RVALID ? M_DOUT : 32'h0;
  assign D_RVALID = (owner == OWN_D_RD) || (owner == OWN_D_WR);
  assign D_RDATA  = (owner == OWN_D_RD) ? M_DOUT : 32'h0;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: behavioural SRAM, reference
// memory, and a response scoreboard keyed by the cycle each reply is due.
module tb_unified_mem_arbiter;

  localparam int AW = 12;
  localparam int SL = 4;

  logic          CLK = 1'b0;
  logic          RSTn;
  logic          I_REQ;
  logic [31:0]   I_ADDR;
  logic          I_GNT;
  logic          I_RVALID;
  logic [31:0]   I_RDATA;
  logic          D_REQ;
  logic          D_WE;
  logic [3:0]    D_BE;
  logic [31:0]   D_ADDR;
  logic [31:0]   D_WDATA;
  logic          D_GNT;
  logic          D_RVALID;
  logic [31:0]   D_RDATA;
  logic          M_CSN;
  logic          M_WEN;
  logic [3:0]    M_BE;
  logic [AW-1:0] M_ADDR;
  logic [31:0]   M_DI;
  logic [31:0]   M_DOUT;

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;

  typedef struct {
    bit          is_i;
    int          due;
    logic [31:0] data;
  } resp_t;

  resp_t       exp_q[$];
  logic [31:0] sram    [0:(1<<AW)-1];
  logic [31:0] ref_mem [0:(1<<AW)-1];

  unified_mem_arbiter #(
    .AWIDTH(AW),
    .STARVE_LIMIT(SL)
  ) dut (
    .CLK(CLK), .RSTn(RSTn),
    .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_GNT(I_GNT),
    .I_RVALID(I_RVALID), .I_RDATA(I_RDATA),
    .D_REQ(D_REQ), .D_WE(D_WE), .D_BE(D_BE), .D_ADDR(D_ADDR),
    .D_WDATA(D_WDATA), .D_GNT(D_GNT),
    .D_RVALID(D_RVALID), .D_RDATA(D_RDATA),
    .M_CSN(M_CSN), .M_WEN(M_WEN), .M_BE(M_BE), .M_ADDR(M_ADDR),
    .M_DI(M_DI), .M_DOUT(M_DOUT)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Behavioural single-port SRAM with byte-enabled writes, 1-cycle read.
  always @(posedge CLK) begin
    if (!M_CSN) begin
      if (!M_WEN) begin
        for (int b = 0; b < 4; b++)
          if (M_BE[b]) sram[M_ADDR][8*b +: 8] <= M_DI[8*b +: 8];
      end else begin
        M_DOUT <= sram[M_ADDR];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: check the response due this cycle, then record this cycle's
  // grant with its expected reply computed from the reference memory.
  always @(negedge CLK) begin
    logic        exp_iv;
    logic        exp_dv;
    logic [31:0] exp_id;
    logic [31:0] exp_dd;
    int          idx;
    if (!RSTn) begin
      exp_q.delete();
      check("rst_i_rvalid", {31'h0, I_RVALID}, 32'h0);
      check("rst_d_rvalid", {31'h0, D_RVALID}, 32'h0);
    end else begin
      exp_iv = 1'b0;
      exp_dv = 1'b0;
      exp_id = 32'h0;
      exp_dd = 32'h0;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        if (exp_q[0].is_i) begin
          exp_iv = 1'b1;
          exp_id = exp_q[0].data;
        end else begin
          exp_dv = 1'b1;
          exp_dd = exp_q[0].data;
        end
        void'(exp_q.pop_front());
      end
      check("i_rvalid", {31'h0, I_RVALID}, {31'h0, exp_iv});
      check("i_rdata",  I_RDATA, exp_id);
      check("d_rvalid", {31'h0, D_RVALID}, {31'h0, exp_dv});
      check("d_rdata",  D_RDATA, exp_dd);
      check("one_gnt",  {31'h0, I_GNT & D_GNT}, 32'h0);
      if (I_GNT) begin
        idx = int'(I_ADDR[AW+1:2]);
        exp_q.push_back('{is_i: 1'b1, due: cyc + 1, data: ref_mem[idx]});
      end else if (D_GNT) begin
        idx = int'(D_ADDR[AW+1:2]);
        if (D_WE) begin
          for (int b = 0; b < 4; b++)
            if (D_BE[b]) ref_mem[idx][8*b +: 8] = D_WDATA[8*b +: 8];
          exp_q.push_back('{is_i: 1'b0, due: cyc + 1, data: 32'h0});
        end else begin
          exp_q.push_back('{is_i: 1'b0, due: cyc + 1, data: ref_mem[idx]});
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    I_REQ   = 1'b0;
    I_ADDR  = 32'h0;
    D_REQ   = 1'b0;
    D_WE    = 1'b0;
    D_BE    = 4'h0;
    D_ADDR  = 32'h0;
    D_WDATA = 32'h0;
  endtask

  task automatic check_m_idle(input string tag);
    check({tag, "_csn"},  {31'h0, M_CSN}, 32'h1);
    check({tag, "_wen"},  {31'h0, M_WEN}, 32'h1);
    check({tag, "_be"},   {28'h0, M_BE},  32'h0);
    check({tag, "_addr"}, {20'h0, M_ADDR}, 32'h0);
    check({tag, "_di"},   M_DI, 32'h0);
    check({tag, "_ignt"}, {31'h0, I_GNT}, 32'h0);
    check({tag, "_dgnt"}, {31'h0, D_GNT}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      sram[i]    = {16'h5A00 ^ 16'(i), 16'(i * 3)};
      ref_mem[i] = {16'h5A00 ^ 16'(i), 16'(i * 3)};
    end
    sram[4]    = 32'hDEAD_BEEF;
    ref_mem[4] = 32'hDEAD_BEEF;
    M_DOUT     = 32'h0;

    // Reset: requests driven but outputs must stay idle.
    RSTn = 1'b0;
    idle_inputs();
    D_REQ = 1'b1; D_WE = 1'b1; D_BE = 4'hF; D_WDATA = 32'hFFFF_FFFF;
    I_REQ = 1'b1; I_ADDR = 32'h10;
    @(negedge CLK);
    @(negedge CLK);
    check_m_idle("reset");
    next_cycle();
    idle_inputs();
    next_cycle();
    RSTn = 1'b1;

    // Lone fetch of word 4.
    next_cycle();
    I_REQ = 1'b1; I_ADDR = 32'h0000_0010;
    @(negedge CLK);
    check("f_gnt",  {31'h0, I_GNT}, 32'h1);
    check("f_csn",  {31'h0, M_CSN}, 32'h0);
    check("f_wen",  {31'h0, M_WEN}, 32'h1);
    check("f_addr", {20'h0, M_ADDR}, 32'h4);
    next_cycle();
    I_REQ = 1'b0;
    @(negedge CLK);
    check("f_rvalid", {31'h0, I_RVALID}, 32'h1);
    check("f_rdata",  I_RDATA, 32'hDEAD_BEEF);
    check("f_no_d",   {31'h0, D_RVALID}, 32'h0);

    // Partial write, then read back.
    next_cycle();
    D_REQ = 1'b1; D_WE = 1'b1; D_BE = 4'b0011;
    D_ADDR = 32'h20; D_WDATA = 32'h1234_5678;
    @(negedge CLK);
    check("w_gnt",  {31'h0, D_GNT}, 32'h1);
    check("w_wen",  {31'h0, M_WEN}, 32'h0);
    check("w_be",   {28'h0, M_BE},  32'h3);
    check("w_addr", {20'h0, M_ADDR}, 32'h8);
    check("w_di",   M_DI, 32'h1234_5678);
    next_cycle();
    D_WE = 1'b0; D_BE = 4'h0; D_WDATA = 32'h0;
    @(negedge CLK);
    check("w_ack",   {31'h0, D_RVALID}, 32'h1);
    check("w_rdata", D_RDATA, 32'h0);
    check("r_be",    {28'h0, M_BE}, 32'h0);
    next_cycle();
    D_REQ = 1'b0;
    @(negedge CLK);
    check("r_low_half", {16'h0, D_RDATA[15:0]}, 32'h0000_5678);

    // Contention: both held, D wins except every fifth grant goes to I.
    next_cycle();
    I_REQ = 1'b1; I_ADDR = 32'h0000_0100;
    D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = 32'h0000_0200;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      check($sformatf("starve_i%0d", k), {31'h0, I_GNT},
            {31'h0, ((k + 1) % 5 == 0)});
      check($sformatf("starve_d%0d", k), {31'h0, D_GNT},
            {31'h0, ((k + 1) % 5 != 0)});
      next_cycle();
    end
    idle_inputs();

    // Back-to-back alternating D and I traffic, with some writes.
    for (int k = 0; k < 12; k++) begin
      if (k % 2 == 0) begin
        I_REQ   = 1'b0;
        D_REQ   = 1'b1;
        D_WE    = (k % 4 == 0);
        D_BE    = 4'(k + 5);
        D_ADDR  = 32'h40 + 32'(4 * (k % 3));
        D_WDATA = 32'hC0DE_0000 + 32'(k);
      end else begin
        D_REQ  = 1'b0;
        I_REQ  = 1'b1;
        I_ADDR = 32'h40 + 32'(4 * ((k + 1) % 3));
      end
      @(negedge CLK);
      check($sformatf("alt_gnt%0d", k), {31'h0, (k % 2 == 0) ? D_GNT : I_GNT},
            32'h1);
      next_cycle();
    end
    idle_inputs();

    // Reset hits right after a D read grant: the reply must be dropped.
    next_cycle();
    D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = 32'h10;
    @(negedge CLK);
    check("rr_gnt", {31'h0, D_GNT}, 32'h1);
    #1;
    RSTn = 1'b0;
    @(negedge CLK);
    check("rr_no_rvalid", {31'h0, D_RVALID}, 32'h0);
    check_m_idle("rr");
    next_cycle();
    idle_inputs();
    next_cycle();
    RSTn = 1'b1;
    @(negedge CLK);
    check("rr_after_rel", {31'h0, D_RVALID}, 32'h0);

    // Aliased D address: 0x4004 maps to word 1.
    next_cycle();
    D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = 32'h0000_4004;
    @(negedge CLK);
    check("alias_addr", {20'h0, M_ADDR}, 32'h1);
    next_cycle();
    D_REQ = 1'b0;
    @(negedge CLK);
    check("alias_rvalid", {31'h0, D_RVALID}, 32'h1);

    // Post-reset fetch resumes normally.
    next_cycle();
    I_REQ = 1'b1; I_ADDR = 32'h0000_0010;
    @(negedge CLK);
    check("resume_gnt", {31'h0, I_GNT}, 32'h1);
    next_cycle();
    idle_inputs();

    repeat (3) next_cycle();
    @(negedge CLK);
    check("q_drained", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
